// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX FIFO controller state encoding.
// Also used by uart_tx and uart_rx.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular byte buffer with synchronous write and combinational head read.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic                   i_Wr_En,
    input  logic [UART_BYTE_W-1:0] i_Wr_Data,
    input  logic                   i_Rd_En,
    output logic [UART_BYTE_W-1:0] o_Rd_Data
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW-1:0]          rd_ptr_d;

    // Next pointer values: advance on accepted write / pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_Wr_En) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (i_Rd_En) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge i_Clock) begin
        if (i_Wr_En) begin
            mem_q[wr_ptr_q] <= i_Wr_Data;
        end
    end

    assign o_Rd_Data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: buffers host writes and launches one frame at a
// time, waiting for the end-of-frame pulse plus one cleanup cycle between bytes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_n,
    input  logic                     i_Wr_En,
    input  logic [UART_BYTE_W-1:0]   i_Wr_Byte,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Overflow,
    output logic                     o_Tx_Dv,
    output logic [UART_BYTE_W-1:0]   o_Tx_Byte,
    input  logic                     i_Tx_Active,
    input  logic                     i_Tx_Done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [1:0]             state_q, state_d;
    logic [AW:0]            count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   overflow_q, overflow_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic                   wr_accept_s;
    logic                   pop_s;
    logic [UART_BYTE_W-1:0] rd_data_s;
    logic                   unused_tx_active_s;

    // Busy status is informational only; launches never wait on it.
    assign unused_tx_active_s = i_Tx_Active;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_Clock   (i_Clock),
        .i_Rst_n   (i_Rst_n),
        .i_Wr_En   (wr_accept_s),
        .i_Wr_Data (i_Wr_Byte),
        .i_Rd_En   (pop_s),
        .o_Rd_Data (rd_data_s)
    );

    // Controller FSM, occupancy bookkeeping and next-cycle output values.
    always_comb begin
        wr_accept_s = i_Wr_En & ~full_q;
        pop_s       = (state_q == ST_IDLE) & ~empty_q;
        state_d     = state_q;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH:    state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d     = (count_d == CNT_FULL);
        empty_d    = (count_d == {(AW+1){1'b0}});
        // A full FIFO drops the write even if a pop frees a slot this cycle.
        overflow_d = i_Wr_En & full_q;
        tx_dv_d    = pop_s;
        if (pop_s) begin
            tx_byte_d = rd_data_s;
        end else begin
            tx_byte_d = tx_byte_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= {(AW+1){1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= {UART_BYTE_W{1'b0}};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = overflow_q;
    assign o_Tx_Dv    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a timestamp-based reference model predicts
// occupancy, overflow and the cycle/byte of every launch; a monitor compares.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct {
        logic [7:0] b;
        int         c;
    } launch_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_byte = 8'h00;
    logic          tx_active = 1'b0;
    logic          tx_done = 1'b0;
    logic          full, empty, overflow, tx_dv;
    logic [AW:0]   count;
    logic [7:0]    tx_byte;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;

    logic [7:0]    mq[$];
    launch_t       sb[$];
    bit            busy = 1'b0;
    int            free_at = 0;
    int            launch_c = -10;
    int            exp_count = 0;
    bit            exp_ovf = 1'b0;
    logic [7:0]    last_byte = 8'h00;
    int            frame_left = 0;
    bit            hold = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Wr_En     (wr_en),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (overflow),
        .o_Tx_Dv     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model. Cycle c starts at posedge c; a write in cycle c is stored
    // for cycle c+1. A launch needs a stored byte and a free launcher; after an
    // end-of-frame pulse in cycle D the next launch can happen at cycle D+3.
    initial forever begin
        int      c;
        bit      acc;
        launch_t e;
        @(posedge clk);
        c = cyc;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            busy      = 1'b0;
            free_at   = 0;
            launch_c  = -10;
            exp_count = 0;
            exp_ovf   = 1'b0;
        end else begin
            acc     = wr_en && (mq.size() < DEPTH);
            exp_ovf = wr_en && !acc;
            if (tx_done && busy && (c > launch_c)) begin
                busy    = 1'b0;
                free_at = c + 3;
            end
            if (!busy && (c + 1 >= free_at) && (mq.size() > 0)) begin
                e.b = mq.pop_front();
                e.c = c + 1;
                sb.push_back(e);
                busy     = 1'b1;
                launch_c = c + 1;
            end
            if (acc) mq.push_back(wr_byte);
            exp_count = mq.size();
        end
        cyc = cyc + 1;
    end

    // Monitor: compares outputs mid-cycle against the model's predictions.
    initial forever begin
        launch_t e;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            last_byte = 8'h00;
            check("rst_count", count, 0);
            check("rst_empty", empty, 1);
            check("rst_full", full, 0);
            check("rst_overflow", overflow, 0);
            check("rst_tx_dv", tx_dv, 0);
            check("rst_tx_byte", tx_byte, 8'h00);
        end else begin
            check("count", count, exp_count);
            check("full", full, exp_count == DEPTH);
            check("empty", empty, exp_count == 0);
            check("overflow", overflow, exp_ovf);
            if (tx_dv) begin
                if (sb.size() == 0) begin
                    check("unexpected_launch", tx_dv, 0);
                end else begin
                    e = sb.pop_front();
                    check("launch_cycle", cyc, e.c);
                    check("launch_byte", tx_byte, e.b);
                    last_byte = e.b;
                end
            end else begin
                if ((sb.size() > 0) && (sb[0].c <= cyc)) begin
                    e = sb.pop_front();
                    check("missing_launch", tx_dv, 1);
                end
                check("tx_byte_hold", tx_byte, last_byte);
            end
        end
    end

    // One cycle of stimulus; also plays the uart_tx role by ending each frame.
    task automatic step(input bit w, input logic [7:0] b, input bit stray);
        @(posedge clk);
        #1;
        wr_en   = w;
        wr_byte = b;
        if (tx_dv) frame_left = hold ? 1000 : $urandom_range(2, 30);
        tx_done   = (frame_left == 1) || stray;
        tx_active = (frame_left > 1);
        if (frame_left > 0) frame_left--;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic reset_pulse(input int n);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        tx_done = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single byte into an empty FIFO.
        step(1'b1, 8'hAB, 1'b0);
        idle(40);

        // Burst of five consecutive writes.
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
        idle(200);

        // Fill while a frame is stuck in flight; 17th write overflows.
        hold = 1'b1;
        step(1'b1, 8'h10, 1'b0);
        idle(3);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        idle(2);
        hold = 1'b0;
        frame_left = 2;
        idle(600);

        // Write in the same cycle as the pop of the only stored byte.
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        idle(80);

        // Reset mid-frame with three bytes queued, then a stray end-of-frame.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        idle(3);
        reset_pulse(2);
        hold = 1'b0;
        frame_left = 4;
        idle(20);

        // End-of-frame pulse while idle and empty.
        step(1'b0, 8'h00, 1'b1);
        idle(10);

        // Randomized traffic with stray end-of-frame pulses.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
        end
        idle(DEPTH * 35 + 50);

        check("scoreboard_drained", sb.size(), 0);
        check("model_drained", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
